reg_id_ex_skid: RTL and testbench

Parametrised ID/EX pipeline stage register for the pipelined core, successor to the fixed-width free-running ID/EX register. Carries the control word, PC+4, two register-file read values, the sign-extended immediate, the zero-filled immediate and the instruction fields. Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, NOP-bubble control gating and a saturating bubble counter. Sits between the decode stage (upstream) and the execute stage (downstream).

---
 rtl/reg_id_ex_skid.sv | 143 ++++++++++++++
 tb/tb_reg_id_ex_skid.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_id_ex_skid.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush, bubble gating of the control word and a bubble counter.
module reg_id_ex_skid #(
  parameter int unsigned CTRL_W  = 11,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INSTR_W = 21,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [CTRL_W-1:0]  decoder_i,
  input  logic [PC_W-1:0]    PC_plus4_i,
  input  logic [DATA_W-1:0]  ReadData1_i,
  input  logic [DATA_W-1:0]  ReadData2_i,
  input  logic [DATA_W-1:0]  signed_extension_i,
  input  logic [DATA_W-1:0]  zero_filled_i,
  input  logic [INSTR_W-1:0] instruction_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CTRL_W-1:0]  decoder_o,
  output logic [PC_W-1:0]    PC_plus4_o,
  output logic [DATA_W-1:0]  ReadData1_o,
  output logic [DATA_W-1:0]  ReadData2_o,
  output logic [DATA_W-1:0]  signed_extension_o,
  output logic [DATA_W-1:0]  zero_filled_o,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam int unsigned PL_W = CTRL_W + PC_W + 4 * DATA_W + INSTR_W;

  // State bit 0 is main_valid, bit 1 is skid_valid, so both valids come
  // straight off the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PL_W-1:0]   main_q;
  logic [PL_W-1:0]   skid_q;
  logic [PL_W-1:0]   in_pl;
  logic [CTRL_W-1:0] main_dec;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic              accept;
  logic              consume;

  assign in_pl = {decoder_i, PC_plus4_i, ReadData1_i, ReadData2_i,
                  signed_extension_i, zero_filled_i, instruction_i};

  assign in_ready_o  = ~state[1];
  assign out_valid_o = state[0];
  assign accept      = in_valid_i & in_ready_o;
  assign consume     = out_valid_o & out_ready_i;

  assign {main_dec, PC_plus4_o, ReadData1_o, ReadData2_o,
          signed_extension_o, zero_filled_o, instruction_o} = main_q;

  // Control word reads as a NOP whenever no payload is presented.
  assign decoder_o    = out_valid_o ? main_dec : CTRL_W'(0);
  assign bubble_cnt_o = cnt_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and payload load selection; flush overrides the state move.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = FULL;
        end
      end
      FULL: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = SKID;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (consume) begin
          load_main_skid = 1'b1;
          state_nxt      = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush_i) begin
      state_nxt = EMPTY;
    end
  end

  // Main and skid payload registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_pl;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pl;
      end
    end
  end

  // Saturating count of cycles where execute was ready but got no payload.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_ready_i && !out_valid_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_id_ex_skid.sv
// Self-checking bench for reg_id_ex_skid: queue-based model plus directed
// scenarios with literal expectations and a randomized stream.
module tb_reg_id_ex_skid;

  localparam int unsigned CW = 11;
  localparam int unsigned PW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 21;
  localparam int unsigned NW = 4;
  localparam int unsigned CNT_MAX = 15;

  typedef struct packed {
    logic [CW-1:0] dec;
    logic [PW-1:0] pc;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] se;
    logic [DW-1:0] zf;
    logic [IW-1:0] ins;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pl_t  din = '0;

  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] dec_o;
  logic [PW-1:0] pc_o;
  logic [DW-1:0] r1_o;
  logic [DW-1:0] r2_o;
  logic [DW-1:0] se_o;
  logic [DW-1:0] zf_o;
  logic [IW-1:0] ins_o;
  logic [NW-1:0] cnt_o;

  reg_id_ex_skid #(
    .CTRL_W(CW), .PC_W(PW), .DATA_W(DW), .INSTR_W(IW), .CNT_W(NW)
  ) dut (
    .clk_i(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .decoder_i(din.dec), .PC_plus4_i(din.pc),
    .ReadData1_i(din.r1), .ReadData2_i(din.r2),
    .signed_extension_i(din.se), .zero_filled_i(din.zf),
    .instruction_i(din.ins),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .decoder_o(dec_o), .PC_plus4_o(pc_o),
    .ReadData1_o(r1_o), .ReadData2_o(r2_o),
    .signed_extension_o(se_o), .zero_filled_o(zf_o),
    .instruction_o(ins_o), .bubble_cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: FIFO of held payloads (capacity 2) and a saturating bubble count.
  pl_t mq[$];
  int unsigned mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic pl_t rnd_pl();
    pl_t p;
    p.dec = CW'($urandom);
    p.pc  = PW'($urandom);
    p.r1  = DW'($urandom);
    p.r2  = DW'($urandom);
    p.se  = DW'($urandom);
    p.zf  = DW'($urandom);
    p.ins = IW'($urandom);
    return p;
  endfunction

  // One clock of the abstract behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit acc;
    bit con;
    acc = in_valid && (mq.size() < 2);
    con = out_ready && (mq.size() > 0);
    if (out_ready && (mq.size() == 0) && (mcnt < CNT_MAX)) mcnt++;
    if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(din);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input bit r, input bit f, input pl_t d);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    din       = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("bubble_cnt", 64'(cnt_o), 64'(mcnt));
      if (mq.size() > 0) begin
        chk("decoder", 64'(dec_o), 64'(mq[0].dec));
        chk("pc_plus4", 64'(pc_o), 64'(mq[0].pc));
        chk("rd1", 64'(r1_o), 64'(mq[0].r1));
        chk("rd2", 64'(r2_o), 64'(mq[0].r2));
        chk("sext", 64'(se_o), 64'(mq[0].se));
        chk("zfill", 64'(zf_o), 64'(mq[0].zf));
        chk("instr", 64'(ins_o), 64'(mq[0].ins));
      end else begin
        chk("decoder_gated", 64'(dec_o), 64'(0));
      end
    end
  end

  initial begin
    pl_t p;
    pl_t a[8];
    logic [NW-1:0] cnt_before;

    // Reset values while reset is held.
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_decoder", 64'(dec_o), 64'(0));
    chk("rst_bubble", 64'(cnt_o), 64'(0));
    chk("rst_pc", 64'(pc_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single payload with 1-cycle latency.
    p = rnd_pl();
    p.dec = 11'h5A5;
    p.pc  = 32'h0000_0104;
    cycle(1, 1, 0, p);
    chk("first_valid", 64'(out_valid), 64'(1));
    chk("first_dec", 64'(dec_o), 64'(11'h5A5));
    chk("first_pc", 64'(pc_o), 64'(32'h104));
    chk("first_ready", 64'(in_ready), 64'(1));

    // Back-to-back stream at full throughput.
    cnt_before = cnt_o;
    for (int i = 0; i < 8; i++) begin
      a[i] = rnd_pl();
      a[i].dec = CW'(11'h0A0 + i);
      cycle(1, 1, 0, a[i]);
      chk("stream_valid", 64'(out_valid), 64'(1));
      chk("stream_dec", 64'(dec_o), 64'(11'h0A0 + i));
    end
    chk("stream_bubble_hold", 64'(cnt_o), 64'(cnt_before));
    cycle(0, 1, 0, '0);
    chk("drain_empty", 64'(out_valid), 64'(0));

    // Backpressure fills main and skid; A2 held upstream.
    for (int i = 0; i < 3; i++) begin
      a[i] = rnd_pl();
      a[i].dec = CW'(11'h1B0 + i);
    end
    cycle(1, 0, 0, a[0]);
    cycle(1, 0, 0, a[1]);
    chk("skid_ready_low", 64'(in_ready), 64'(0));
    cycle(1, 0, 0, a[2]);
    chk("skid_main_a0", 64'(dec_o), 64'(11'h1B0));
    chk("skid_still_full", 64'(in_ready), 64'(0));
    cycle(1, 1, 0, a[2]);
    chk("skid_out_a1", 64'(dec_o), 64'(11'h1B1));
    cycle(1, 1, 0, a[2]);
    chk("skid_out_a2", 64'(dec_o), 64'(11'h1B2));
    cycle(0, 1, 0, '0);
    chk("skid_drained", 64'(out_valid), 64'(0));

    // Flush in SKID with a new input in flight.
    cycle(1, 0, 0, rnd_pl());
    cycle(1, 0, 0, rnd_pl());
    chk("pre_flush_full", 64'(in_ready), 64'(0));
    cycle(1, 0, 1, rnd_pl());
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_dec", 64'(dec_o), 64'(0));
    chk("flush_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, '0);
      chk("flush_gone", 64'(out_valid), 64'(0));
    end

    // Bubble counter saturation from a fresh reset.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 1, 0, '0);
      chk("bubble_sat", 64'(cnt_o), 64'((k < 15) ? k : 15));
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 10) < 7, ($urandom % 32) == 0, rnd_pl());
    end

    // Asynchronous reset with both entries valid.
    cycle(1, 0, 0, rnd_pl());
    cycle(1, 0, 0, rnd_pl());
    chk("pre_arst_full", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_bubble", 64'(cnt_o), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    chk("arst_dec", 64'(dec_o), 64'(0));
    mq.delete();
    mcnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 3) != 0, ($urandom % 2) == 0, ($urandom % 40) == 0, rnd_pl());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
